uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Memory-mapped UART receiver, the input-direction counterpart of the SoC's
//  UART transmit peripheral; a bus responder on the CPU memory bus.
//  - Deserialises 8N1 frames from rx_i.
//  - Buffers received bytes in a FIFO.
//  - CPU reads bytes and status through two word registers.
// PARAMETERS
//  IO_MEM_MAP_BIT      22          addr bit that selects the IO space
//  UART_RX_MEM_MAP_BIT 2           addr bit (word-aligned) that selects this block
//  CLK_FREQ_HZ         50_000_000  clk frequency
//  BAUD_RATE           115_200     line rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (>=4)
//  FIFO_DEPTH          16          byte entries; power of 2, >=2
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous reset, ACTIVE-LOW (0 = reset)
//  mem_addr_i   in   32  bus byte address
//  mem_rstrb_i  in   1   read strobe
//  mem_rdata_o  out  32  read data, registered
//  mem_wmask_i  in   4   byte write enables; 0 = no write
//  mem_wdata_i  in   32  write data
//  rx_i         in   1   serial line; idle high; asynchronous to clk
//  rx_irq_o     out  1   1 while the FIFO is non-empty
// BEHAVIOUR
//  Reset: mem_rdata_o=0, rx_irq_o=0, FIFO empty, flags cleared, FSM IDLE,
//   synchroniser flops preset to 1.
//  Select: sel = mem_addr_i[IO_MEM_MAP_BIT] & mem_addr_i[UART_RX_MEM_MAP_BIT].
//   Register index = mem_addr_i[3] (0 DATA, 1 STATUS). Unselected: no effect.
//  Read: on the clk edge where sel & mem_rstrb_i, mem_rdata_o loads the
//   addressed value. Data is valid the next cycle and is held until the next
//   selected read.
//  DATA read: {24'b0, head byte} and pops one entry. If the FIFO is empty it
//   returns 0 and does not pop.
//  STATUS read (no side effect):
//   [0] not empty, [1] full, [2] overrun, [3] frame_err,
//   [15:8] fill level, all other bits 0.
//  STATUS write (sel & wmask[0]): wdata[2]=1 clears overrun; wdata[3]=1 clears
//   frame_err (W1C). A flag set in the same cycle as its clear stays set.
//  DATA write: ignored.
//  Sync: rx_i passes through 2 flops (rx_s). All FSM decisions use rx_s.
//  Baud counter: reloads at every state entry; counts CLKS_PER_BIT-1 down to 0.
//  FSM:
//   IDLE:  rx_s==0 -> START, wait CLKS_PER_BIT/2.
//   START: mid-bit sample. rx_s==1 is a false start -> IDLE.
//          rx_s==0 -> DATA, bit index 0.
//   DATA:  sample every CLKS_PER_BIT, shift in LSB first. After bit 7 -> STOP.
//   STOP:  sample after CLKS_PER_BIT.
//          1: push the byte -> IDLE.
//          0: set frame_err, drop the byte -> BREAK.
//   BREAK: wait for rx_s==1 -> IDLE. No frames are received in this state.
//  FIFO: rd/wr pointers log2(FIFO_DEPTH)+1 bits wide, wrap naturally.
//   full  = MSBs differ and lower bits equal.
//   Push while full without a same-cycle pop: byte dropped, overrun set.
//   Push+pop in the same cycle: both happen, level unchanged. This holds even
//   when the FIFO is full (no overrun is set).
//   Pop of an empty FIFO in the push cycle: returns 0; the pushed byte is
//   kept for the next read.
//  rx_irq_o: combinational from FIFO non-empty.
//  Reset mid-frame: immediate return to IDLE; the partial byte is discarded.
// TESTING  (CLK_FREQ_HZ=1_000_000, BAUD_RATE=100_000 -> 10 clk/bit, FIFO_DEPTH=4)
//  1 Send 0xA5 8N1 -> STATUS=0x0000_0101, rx_irq_o=1; DATA read=0xA5, then
//    STATUS=0x0000_0000.
//  2 Send 0x00,0xFF,0x3C,0x81 back to back -> level=4, full=1; four reads give
//    them in order; a fifth read returns 0.
//  3 Send 5 bytes with FIFO_DEPTH=4, no reads -> level=4, overrun=1; the fifth
//    byte is lost. Write STATUS 0x4 -> overrun=0.
//  4 Send 0x55 with the stop bit forced 0, then hold the line low for 30 clk ->
//    frame_err=1, level=0. After the line returns high, send 0x12 -> it is
//    received correctly.
//  5 Glitch rx_i low for 3 clk -> false start; no push; FSM back in IDLE.
//  6 Full FIFO, time a DATA read in the cycle of a stop-bit push -> level stays
//    4, overrun stays 0. Also assert rst low mid-byte -> all outputs return to
//    their reset values.

Source files
------------

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Memory-mapped UART receiver. It turns 8N1 serial frames into bytes, keeps
// them in a small FIFO, and serves two word registers on the CPU memory bus.
//
//   DATA   (mem_addr_i[3] = 0) : read {24'b0, oldest byte} and pop it;
//                                an empty FIFO reads as 0. Writes are ignored.
//   STATUS (mem_addr_i[3] = 1) : [0] not empty, [1] full, [2] overrun,
//                                [3] frame error, [15:8] fill level.
//                                Writing 1 to bit 2 or bit 3 clears that flag.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active low
//   mem_addr_i   bus byte address; the block responds only when both
//                mem_addr_i[IO_MEM_MAP_BIT] and mem_addr_i[UART_RX_MEM_MAP_BIT]
//                are set
//   mem_rstrb_i  read strobe
//   mem_rdata_o  registered read data, held until the next selected read
//   mem_wmask_i  byte write enables (only byte 0 matters here)
//   mem_wdata_i  write data
//   rx_i         serial input, idle high, asynchronous to clk
//   rx_irq_o     high while the FIFO holds at least one byte
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int IO_MEM_MAP_BIT      = 22,
    parameter int UART_RX_MEM_MAP_BIT = 2,
    parameter int CLK_FREQ_HZ         = 50_000_000,
    parameter int BAUD_RATE           = 115_200,
    parameter int FIFO_DEPTH          = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr_i,
    input  logic        mem_rstrb_i,
    output logic [31:0] mem_rdata_o,
    input  logic [3:0]  mem_wmask_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        rx_i,
    output logic        rx_irq_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int PTR_W        = AW + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // Serial front end
    logic             r_rxMeta;
    logic             r_rxSync;

    // Receiver FSM and its datapath
    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bitIdx;
    logic [7:0]       r_shift;
    logic             w_cntLoad;
    logic [CNT_W-1:0] w_cntLoadVal;
    logic             w_shiftEn;
    logic             w_bitClr;
    logic             w_bitInc;
    logic             w_push;
    logic             w_frameErrSet;

    // FIFO
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] w_level;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_wrEn;

    // Bus side
    logic             w_sel;
    logic             w_rdStb;
    logic             w_statusWr;
    logic             w_overrunSet;
    logic             r_overrun;
    logic             r_frameErr;
    logic [31:0]      w_status;
    logic [31:0]      w_rdValue;
    logic             w_unused;

    // Two-flop synchroniser. Both flops reset to the idle line level so a
    // reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rxMeta <= 1'b1;
            r_rxSync <= 1'b1;
        end else begin
            r_rxMeta <= rx_i;
            r_rxSync <= r_rxMeta;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and datapath controls. The baud counter is reloaded on every
    // state entry (and between data bits); a state acts when it reaches 0.
    // START waits half a bit so that all later samples land mid-bit.
    always_comb begin
        w_nextState   = r_state;
        w_cntLoad     = 1'b0;
        w_cntLoadVal  = CNT_FULL;
        w_shiftEn     = 1'b0;
        w_bitClr      = 1'b0;
        w_bitInc      = 1'b0;
        w_push        = 1'b0;
        w_frameErrSet = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rxSync) begin
                    w_nextState  = S_START;
                    w_cntLoad    = 1'b1;
                    w_cntLoadVal = CNT_HALF;
                end
            end
            S_START: begin
                if (r_cnt == '0) begin
                    if (r_rxSync) begin
                        w_nextState = S_IDLE;
                    end else begin
                        w_nextState = S_DATA;
                        w_cntLoad   = 1'b1;
                        w_bitClr    = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (r_cnt == '0) begin
                    w_shiftEn = 1'b1;
                    w_cntLoad = 1'b1;
                    if (r_bitIdx == 3'd7) begin
                        w_nextState = S_STOP;
                    end else begin
                        w_bitInc = 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == '0) begin
                    if (r_rxSync) begin
                        w_push      = 1'b1;
                        w_nextState = S_IDLE;
                    end else begin
                        w_frameErrSet = 1'b1;
                        w_nextState   = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (r_rxSync) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Baud counter, bit index and shift register. Bits arrive LSB first, so
    // each new sample enters at the top and moves down.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
        end else begin
            if (w_cntLoad) begin
                r_cnt <= w_cntLoadVal;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_bitClr) begin
                r_bitIdx <= '0;
            end else if (w_bitInc) begin
                r_bitIdx <= r_bitIdx + 1'b1;
            end
            if (w_shiftEn) begin
                r_shift <= {r_rxSync, r_shift[7:1]};
            end
        end
    end

    assign w_sel      = mem_addr_i[IO_MEM_MAP_BIT] & mem_addr_i[UART_RX_MEM_MAP_BIT];
    assign w_rdStb    = w_sel & mem_rstrb_i;
    assign w_statusWr = w_sel & mem_wmask_i[0] & mem_addr_i[3];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_level = r_wrPtr - r_rdPtr;
    assign w_empty = (r_wrPtr == r_rdPtr);
    assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                     (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // accepted when a DATA read happens alongside it. A pop is gated by the
    // current empty flag, which keeps a byte pushed during a read of an empty
    // FIFO for the next read.
    assign w_pop        = w_rdStb & ~mem_addr_i[3] & ~w_empty;
    assign w_wrEn       = w_push & (~w_full | w_pop);
    assign w_overrunSet = w_push & w_full & ~w_pop;

    // FIFO storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_wrEn) begin
            r_mem[r_wrPtr[AW-1:0]] <= r_shift;
        end
    end

    // FIFO pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_wrEn) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

    // Sticky error flags with write-one-to-clear. A set in the same cycle as
    // a clear wins so an event is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overrun  <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_overrun  <= w_overrunSet |
                          (r_overrun & ~(w_statusWr & mem_wdata_i[2]));
            r_frameErr <= w_frameErrSet |
                          (r_frameErr & ~(w_statusWr & mem_wdata_i[3]));
        end
    end

    assign w_status = {16'h0000, 8'(w_level), 4'h0,
                       r_frameErr, r_overrun, w_full, ~w_empty};

    always_comb begin
        w_rdValue = '0;
        if (mem_addr_i[3]) begin
            w_rdValue = w_status;
        end else if (!w_empty) begin
            w_rdValue = {24'h000000, r_mem[r_rdPtr[AW-1:0]]};
        end
    end

    // Registered read port, updated only by selected reads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_rdata_o <= '0;
        end else if (w_rdStb) begin
            mem_rdata_o <= w_rdValue;
        end
    end

    assign rx_irq_o = ~w_empty;

    // Bus bits this block does not decode
    assign w_unused = &{1'b0, mem_addr_i, mem_wdata_i, mem_wmask_i};

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx at 10 clocks per bit with a 4-entry FIFO.
// Serial frames are driven on rx_i; every byte that should reach the FIFO is
// pushed on a queue and popped when the bench reads DATA.
// ---------------------------------------------------------------------------
`timescale 1ns / 1ps

module tb_uart_rx;

    localparam int          CPB       = 10;
    localparam int          DEPTH     = 4;
    localparam logic [31:0] ADDR_DATA = 32'h0040_0004;
    localparam logic [31:0] ADDR_STAT = 32'h0040_000C;

    logic        clk;
    logic        rst;
    logic [31:0] mem_addr_i;
    logic        mem_rstrb_i;
    logic [31:0] mem_rdata_o;
    logic [3:0]  mem_wmask_i;
    logic [31:0] mem_wdata_i;
    logic        rx_i;
    logic        rx_irq_o;

    int          vecCount  = 0;
    int          missCount = 0;

    // Scoreboard and flag model
    logic [7:0]  expQ[$];
    logic        modelOverrun  = 1'b0;
    logic        modelFrameErr = 1'b0;

    uart_rx #(
        .IO_MEM_MAP_BIT      (22),
        .UART_RX_MEM_MAP_BIT (2),
        .CLK_FREQ_HZ         (1_000_000),
        .BAUD_RATE           (100_000),
        .FIFO_DEPTH          (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr_i  (mem_addr_i),
        .mem_rstrb_i (mem_rstrb_i),
        .mem_rdata_o (mem_rdata_o),
        .mem_wmask_i (mem_wmask_i),
        .mem_wdata_i (mem_wdata_i),
        .rx_i        (rx_i),
        .rx_irq_o    (rx_irq_o)
    );

    // 1 MHz clock
    initial clk = 1'b0;
    always #500 clk = ~clk;

    // Run-time bound
    initial begin
        #20_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, need finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] expStatus();
        logic [7:0] lvl;
        lvl = 8'(expQ.size());
        return {16'h0000, lvl, 4'h0, modelFrameErr, modelOverrun,
                (expQ.size() == DEPTH), (expQ.size() != 0)};
    endfunction

    function automatic void modelPush(input logic [7:0] b);
        if (expQ.size() < DEPTH) expQ.push_back(b);
        else modelOverrun = 1'b1;
    endfunction

    // One 8N1 frame on rx_i, starting at the next falling edge
    task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
        @(negedge clk);
        rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_i = stopBit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic busRead(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        mem_addr_i  = a;
        mem_rstrb_i = 1'b1;
        @(posedge clk);
        #1;
        mem_rstrb_i = 1'b0;
        mem_addr_i  = '0;
        d = mem_rdata_o;
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] w);
        @(negedge clk);
        mem_addr_i  = a;
        mem_wmask_i = 4'hF;
        mem_wdata_i = w;
        @(posedge clk);
        #1;
        mem_wmask_i = 4'h0;
        mem_wdata_i = '0;
        mem_addr_i  = '0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vecCount++;
        if (mem_rdata_o !== 32'h0) begin
            missCount++;
            $display("[TB] FAIL reset_rdata: got %h, need %h", mem_rdata_o, 32'h0);
        end
        vecCount++;
        if (rx_irq_o !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL reset_irq: got %b, need 0", rx_irq_o);
        end
        rst = 1'b1;
        busRead(ADDR_STAT, d);
        vecCount++;
        if (d !== expStatus()) begin
            missCount++;
            $display("[TB] FAIL reset_status: got %h, need %h", d, expStatus());
        end
    endtask

    task automatic test_single_byte();
        logic [31:0] d;
        logic [31:0] e;
        applyStimulus(8'hA5, 1'b1);
        modelPush(8'hA5);
        busRead(ADDR_STAT, d);
        vecCount++;
        if (d !== 32'h0000_0101 || d !== expStatus()) begin
            missCount++;
            $display("[TB] FAIL single_status: got %h, need %h", d, 32'h0000_0101);
        end
        vecCount++;
        if (rx_irq_o !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL single_irq: got %b, need 1", rx_irq_o);
        end
        busRead(ADDR_DATA, d);
        e = {24'h0, expQ.pop_front()};
        vecCount++;
        if (d !== e) begin
            missCount++;
            $display("[TB] FAIL single_data: got %h, need %h", d, e);
        end
        busRead(ADDR_STAT, d);
        vecCount++;
        if (d !== expStatus()) begin
            missCount++;
            $display("[TB] FAIL single_status_after: got %h, need %h", d, expStatus());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [31:0] e;
        logic [7:0]  pat [4];
        pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h3C; pat[3] = 8'h81;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(pat[i], 1'b1);
            modelPush(pat[i]);
        end
        busRead(ADDR_STAT, d);
        vecCount++;
        if (d !== expStatus()) begin
            missCount++;
            $display("[TB] FAIL b2b_status_full: got %h, need %h", d, expStatus());
        end
        for (int i = 0; i < 5; i++) begin
            busRead(ADDR_DATA, d);
            e = (expQ.size() != 0) ? {24'h0, expQ.pop_front()} : 32'h0;
            vecCount++;
            if (d !== e) begin
                missCount++;
                $display("[TB] FAIL b2b_data%0d: got %h, need %h", i, d, e);
            end
        end
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        logic [31:0] e;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'h40 + 8'(i), 1'b1);
            modelPush(8'h40 + 8'(i));
        end
        busRead(ADDR_STAT, d);
        vecCount++;
        if (d !== expStatus()) begin
            missCount++;
            $display("[TB] FAIL overrun_status: got %h, need %h", d, expStatus());
        end
        busWrite(ADDR_STAT, 32'h4);
        modelOverrun = 1'b0;
        busRead(ADDR_STAT, d);
        vecCount++;
        if (d !== expStatus()) begin
            missCount++;
            $display("[TB] FAIL overrun_clear: got %h, need %h", d, expStatus());
        end
        for (int i = 0; i < 5; i++) begin
            busRead(ADDR_DATA, d);
            e = (expQ.size() != 0) ? {24'h0, expQ.pop_front()} : 32'h0;
            vecCount++;
            if (d !== e) begin
                missCount++;
                $display("[TB] FAIL overrun_data%0d: got %h, need %h", i, d, e);
            end
        end
    endtask

    task automatic test_frame_error();
        logic [31:0] d;
        logic [31:0] e;
        applyStimulus(8'h55, 1'b0);
        modelFrameErr = 1'b1;
        repeat (30) @(negedge clk);
        rx_i = 1'b1;
        repeat (5) @(negedge clk);
        busRead(ADDR_STAT, d);
        vecCount++;
        if (d !== expStatus()) begin
            missCount++;
            $display("[TB] FAIL frame_status: got %h, need %h", d, expStatus());
        end
        applyStimulus(8'h12, 1'b1);
        modelPush(8'h12);
        busRead(ADDR_STAT, d);
        vecCount++;
        if (d !== expStatus()) begin
            missCount++;
            $display("[TB] FAIL frame_recover_status: got %h, need %h", d, expStatus());
        end
        busRead(ADDR_DATA, d);
        e = {24'h0, expQ.pop_front()};
        vecCount++;
        if (d !== e) begin
            missCount++;
            $display("[TB] FAIL frame_recover_data: got %h, need %h", d, e);
        end
        busWrite(ADDR_STAT, 32'h8);
        modelFrameErr = 1'b0;
        busRead(ADDR_STAT, d);
        vecCount++;
        if (d !== expStatus()) begin
            missCount++;
            $display("[TB] FAIL frame_clear: got %h, need %h", d, expStatus());
        end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        logic [31:0] e;
        @(negedge clk);
        rx_i = 1'b0;
        repeat (3) @(negedge clk);
        rx_i = 1'b1;
        repeat (20) @(negedge clk);
        busRead(ADDR_STAT, d);
        vecCount++;
        if (d !== expStatus()) begin
            missCount++;
            $display("[TB] FAIL glitch_status: got %h, need %h", d, expStatus());
        end
        applyStimulus(8'h3A, 1'b1);
        modelPush(8'h3A);
        busRead(ADDR_DATA, d);
        e = {24'h0, expQ.pop_front()};
        vecCount++;
        if (d !== e) begin
            missCount++;
            $display("[TB] FAIL glitch_next_data: got %h, need %h", d, e);
        end
    endtask

    // Fills the FIFO, then lands a DATA read on the stop-bit push edge of a
    // fifth frame (97 clocks after its start bit begins).
    task automatic test_push_pop_full();
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] eFirst;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h11 * 8'(i + 1), 1'b1);
            modelPush(8'h11 * 8'(i + 1));
        end
        eFirst = {24'h0, expQ.pop_front()};
        expQ.push_back(8'hC7);
        fork
            applyStimulus(8'hC7, 1'b1);
            begin
                @(negedge clk);
                repeat (96) @(negedge clk);
                busRead(ADDR_DATA, d);
            end
        join
        vecCount++;
        if (d !== eFirst) begin
            missCount++;
            $display("[TB] FAIL pushpop_data: got %h, need %h", d, eFirst);
        end
        busRead(ADDR_STAT, d);
        vecCount++;
        if (d !== expStatus()) begin
            missCount++;
            $display("[TB] FAIL pushpop_status: got %h, need %h", d, expStatus());
        end
        for (int i = 0; i < 4; i++) begin
            busRead(ADDR_DATA, d);
            e = (expQ.size() != 0) ? {24'h0, expQ.pop_front()} : 32'h0;
            vecCount++;
            if (d !== e) begin
                missCount++;
                $display("[TB] FAIL pushpop_drain%0d: got %h, need %h", i, d, e);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        logic [31:0] e;
        logic [7:0]  partial;
        applyStimulus(8'h9E, 1'b1);
        modelPush(8'h9E);
        busRead(ADDR_STAT, d);
        vecCount++;
        if (d !== expStatus()) begin
            missCount++;
            $display("[TB] FAIL midrst_pre_status: got %h, need %h", d, expStatus());
        end
        partial = 8'hB5;
        @(negedge clk);
        rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_i = partial[i];
            repeat (CPB) @(negedge clk);
        end
        rst = 1'b0;
        rx_i = 1'b1;
        expQ.delete();
        #1;
        vecCount++;
        if (mem_rdata_o !== 32'h0) begin
            missCount++;
            $display("[TB] FAIL midrst_rdata: got %h, need %h", mem_rdata_o, 32'h0);
        end
        vecCount++;
        if (rx_irq_o !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL midrst_irq: got %b, need 0", rx_irq_o);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (CPB * 10) @(negedge clk);
        busRead(ADDR_STAT, d);
        vecCount++;
        if (d !== expStatus()) begin
            missCount++;
            $display("[TB] FAIL midrst_status: got %h, need %h", d, expStatus());
        end
        applyStimulus(8'h6B, 1'b1);
        modelPush(8'h6B);
        busRead(ADDR_DATA, d);
        e = {24'h0, expQ.pop_front()};
        vecCount++;
        if (d !== e) begin
            missCount++;
            $display("[TB] FAIL midrst_next_data: got %h, need %h", d, e);
        end
    endtask

    initial begin
        rst         = 1'b0;
        rx_i        = 1'b1;
        mem_addr_i  = '0;
        mem_rstrb_i = 1'b0;
        mem_wmask_i = 4'h0;
        mem_wdata_i = '0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overrun();
        test_frame_error();
        test_glitch();
        test_push_pop_full();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
